subtree_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one downstream resource among the NUM_REQ

---
 rtl/subtree_rr_arbiter_pkg.sv | 22 ++
 rtl/subtree_rr_arbiter_if.sv | 33 +++
 rtl/subtree_rr_arbiter_rr_pick.sv | 41 ++++
 rtl/subtree_rr_arbiter.sv | 108 ++++++++++
 tb/tb_subtree_rr_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/subtree_rr_arbiter_pkg.sv
// Shared types, defaults and the modulo-wrap helper for the subtree round-robin arbiter.
package subtree_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int NUM_REQ_DEFAULT  = 5;
  localparam int MAX_HOLD_DEFAULT = 16;

  // Position 'step' places after 'base' on a ring of n requesters (step 0 = base+1).
  // Wraps at n, not at a power of two, so results always stay in 0..n-1.
  function automatic int rr_wrap(input int base, input int step, input int n);
    int s;
    s = base + 1 + step;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/subtree_rr_arbiter_if.sv
// Request/grant bundle between the subtree children and the arbiter.
//
// Handshake: a child raises req_i and holds it for the whole transaction;
// it owns the resource while its gnt_o bit is 1 (busy_o high, gnt_idx_o = its
// index). The transaction ends on the cycle where req_i and last_i are both
// high for the owner; dropping req_i early aborts it, and timeout_o pulses when
// the arbiter revokes the grant itself. last_i has meaning only together with req_i.
interface subtree_rr_arbiter_if
  import subtree_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) ();
  localparam int IDXW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] last_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [IDXW-1:0]    gnt_idx_o;
  logic               busy_o;
  logic               timeout_o;

  // Requester side (children)
  modport master (
    output req_i, last_i,
    input  gnt_o, gnt_idx_o, busy_o, timeout_o
  );

  // Arbiter side
  modport slave (
    input  req_i, last_i,
    output gnt_o, gnt_idx_o, busy_o, timeout_o
  );
endinterface

// File: rtl/subtree_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate requests so ptr+1 is bit 0,
// priority-encode the lowest set bit, then map the offset back to an index.
module rr_pick
  import subtree_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic               found,
  output logic [IDXW-1:0]    idx
);

  logic [NUM_REQ-1:0] rot;
  logic [IDXW-1:0]    off;

  // Rotate: rot[k] is the requester k+1 places after the last winner
  always_comb begin
    rot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rot[k] = req[rr_wrap(int'(ptr), k, NUM_REQ)];
    end
  end

  // Priority-encode: scan downwards so the lowest set offset wins
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IDXW'(k);
      end
    end
  end

  // Un-rotate back to a requester index, wrapping at NUM_REQ
  assign idx = IDXW'(rr_wrap(int'(ptr), int'(off), NUM_REQ));

endmodule

// File: rtl/subtree_rr_arbiter.sv
// Round-robin owner arbiter for one shared downstream resource.
// IDLE picks an owner, OWN holds it until last/abort/watchdog, GAP forces a
// one-cycle turnaround before the next pick.
module subtree_rr_arbiter
  import subtree_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int IDXW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  subtree_rr_arbiter_if.slave bus,
  output arb_state_t         state_dbg
);

  localparam int              HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IDXW-1:0] PTR_RST   = IDXW'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [IDXW-1:0]    ptr_q;
  logic [IDXW-1:0]    own_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [HW-1:0]      hold_q;

  logic               found;
  logic [IDXW-1:0]    pick_idx;
  logic               own_req, own_last;
  logic               wd_hit, own_exit, wd_revoke;
  logic               busy, timeout;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_pick (
    .req   (bus.req_i),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick_idx)
  );

  // Owner view of the request lines; everyone else is ignored while in OWN
  always_comb begin
    own_req   = bus.req_i[own_q];
    own_last  = bus.last_i[own_q];
    wd_hit    = (hold_q == HOLD_LAST);
    own_exit  = (own_req & own_last) | ~own_req | wd_hit;
    // Completion and abort both take precedence over the watchdog
    wd_revoke = own_req & ~own_last & wd_hit;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = OWN;
      OWN:     if (own_exit) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    busy    = (state_q == OWN);
    timeout = (state_q == OWN) & wd_revoke;
  end

  // Owner, grant, round-robin pointer and hold counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= PTR_RST;
      own_q  <= '0;
      gnt_q  <= '0;
      hold_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_q  <= NUM_REQ'(1) << pick_idx;
            own_q  <= pick_idx;
            ptr_q  <= pick_idx;
            hold_q <= '0;
          end
        end
        OWN: begin
          if (own_exit)    gnt_q  <= '0;
          else if (!wd_hit) hold_q <= hold_q + 1'b1;
        end
        default: gnt_q <= '0;
      endcase
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.gnt_idx_o = own_q;
  assign bus.busy_o    = busy;
  assign bus.timeout_o = timeout;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_subtree_rr_arbiter.sv
// Bench for subtree_rr_arbiter: cycle-level reference model of ownership
// rules plus directed scenarios checked against hand-derived constants.
module tb_subtree_rr_arbiter;
  import subtree_arb_pkg::*;

  localparam int NR   = 5;
  localparam int MH   = 16;
  localparam int IW   = $clog2(NR);

  logic       clk;
  logic       rst;
  arb_state_t state_dbg;

  subtree_rr_arbiter_if #(.NUM_REQ(NR)) bus ();

  subtree_rr_arbiter #(
    .NUM_REQ  (NR),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [IW-1:0] exp_q[$];
  logic [NR-1:0] log_gnt[$];
  logic          log_busy[$];
  logic          log_to[$];
  int            got_idx[$];
  int            got_cyc[$];
  logic          prev_busy;

  // Reference model: who owns the resource, how long, whether we are in the
  // turnaround gap, and who won last.
  int m_owner;
  int m_hold;
  bit m_gap;
  int m_last_win;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_hold     = 0;
    m_gap      = 1'b0;
    m_last_win = NR - 1;
    exp_q.delete();
    prev_busy  = 1'b0;
  endtask

  // Advance the model across one rising edge given this cycle's inputs
  task automatic model_advance(input logic [NR-1:0] r, input logic [NR-1:0] l);
    if (m_owner >= 0) begin
      if ((r[m_owner] && l[m_owner]) || !r[m_owner] || m_hold == MH - 1) begin
        m_owner = -1;
        m_gap   = 1'b1;
      end else if (m_hold < MH - 1) begin
        m_hold++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      for (int off = 1; off <= NR; off++) begin
        int c;
        c = (m_last_win + off) % NR;
        if (r[c]) begin
          m_owner    = c;
          m_last_win = c;
          m_hold     = 0;
          exp_q.push_back(IW'(c));
          break;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Apply inputs for one cycle, check outputs at the falling edge, then
  // advance the model at the rising edge.
  task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] l);
    logic [NR-1:0] exp_gnt;
    arb_state_t    exp_state;
    logic          exp_to;
    logic [NR-1:0] s_gnt;
    logic          s_busy, s_to;
    logic [IW-1:0] s_idx;
    bus.req_i  = r;
    bus.last_i = l;
    @(negedge clk);
    s_gnt  = bus.gnt_o;
    s_busy = bus.busy_o;
    s_to   = bus.timeout_o;
    s_idx  = bus.gnt_idx_o;
    exp_gnt   = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
    exp_state = (m_owner >= 0) ? OWN : (m_gap ? GAP : IDLE);
    exp_to    = (m_owner >= 0) && r[m_owner] && !l[m_owner] && (m_hold == MH - 1);
    check_val("gnt", 32'(s_gnt), 32'(exp_gnt));
    check_val("busy", 32'(s_busy), 32'(m_owner >= 0));
    check_val("timeout", 32'(s_to), 32'(exp_to));
    check_val("state", 32'(state_dbg), 32'(exp_state));
    if (m_owner >= 0) check_val("gnt_idx", 32'(s_idx), 32'(m_owner));
    if (s_busy && !prev_busy) begin
      got_idx.push_back(int'(s_idx));
      got_cyc.push_back(cyc);
      check_val("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_val("sb_grant_idx", 32'(s_idx), 32'(exp_q.pop_front()));
    end
    prev_busy = s_busy;
    log_gnt.push_back(s_gnt);
    log_busy.push_back(s_busy);
    log_to.push_back(s_to);
    cyc++;
    @(posedge clk);
    model_advance(r, l);
    #1;
  endtask

  task automatic clear_logs();
    log_gnt.delete();
    log_busy.delete();
    log_to.delete();
    got_idx.delete();
    got_cyc.delete();
  endtask

  function automatic int count_ones(input logic q[$], input int from, input int to);
    int s;
    s = 0;
    for (int i = from; i <= to; i++) if (q[i]) s++;
    return s;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [NR-1:0] r, l;

    rst        = 1'b1;
    bus.req_i  = '0;
    bus.last_i = '0;
    model_reset();
    #3;
    check_val("rst_gnt", 32'(bus.gnt_o), 32'd0);
    check_val("rst_busy", 32'(bus.busy_o), 32'd0);
    check_val("rst_idx", 32'(bus.gnt_idx_o), 32'd0);
    check_val("rst_timeout", 32'(bus.timeout_o), 32'd0);
    check_val("rst_state", 32'(state_dbg), 32'(IDLE));
    #20;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: idle with no requests
    for (int k = 0; k < 10; k++) step('0, '0);

    // 2: all request, each owner finishes on its second OWN cycle
    clear_logs();
    for (int k = 0; k < 24; k++) begin
      l = (m_owner >= 0 && m_hold == 1) ? (NR'(1) << m_owner) : '0;
      step(5'b11111, l);
    end
    check_val("t2_ngrants", 32'(got_idx.size()), 32'd6);
    if (got_idx.size() >= 6) begin
      check_val("t2_order0", 32'(got_idx[0]), 32'd0);
      check_val("t2_order1", 32'(got_idx[1]), 32'd1);
      check_val("t2_order2", 32'(got_idx[2]), 32'd2);
      check_val("t2_order3", 32'(got_idx[3]), 32'd3);
      check_val("t2_order4", 32'(got_idx[4]), 32'd4);
      check_val("t2_order5", 32'(got_idx[5]), 32'd0);
      for (int i = 1; i < 6; i++) check_val("t2_spacing", 32'(got_cyc[i] - got_cyc[i-1]), 32'd4);
    end
    for (int k = 0; k < 2; k++) step('0, '0);

    // 3: lone requester never finishes -> watchdog
    clear_logs();
    for (int k = 0; k < 20; k++) step(5'b00100, '0);
    for (int k = 1; k <= 16; k++) check_val("t3_gnt_held", 32'(log_gnt[k]), 32'b00100);
    check_val("t3_to_early", 32'(count_ones(log_to, 0, 15)), 32'd0);
    check_val("t3_to_pulse", 32'(log_to[16]), 32'd1);
    check_val("t3_to_after", 32'(count_ones(log_to, 17, 19)), 32'd0);
    check_val("t3_gap", 32'(log_gnt[17]), 32'd0);
    check_val("t3_regrant", 32'(log_gnt[19]), 32'b00100);
    for (int k = 0; k < 3; k++) step('0, '0);

    // 4: owner 3 aborts, pending 1 and 4 -> 4 wins next
    clear_logs();
    for (int k = 0; k < 3; k++) step(5'b11010, '0);
    for (int k = 0; k < 3; k++) step(5'b10010, '0);
    step(5'b10000, 5'b10000);
    for (int k = 0; k < 2; k++) step('0, '0);
    check_val("t4_owner3", 32'(log_gnt[2]), 32'b01000);
    check_val("t4_abort_to", 32'(log_to[3]), 32'd0);
    check_val("t4_drop", 32'(log_gnt[4]), 32'd0);
    check_val("t4_next4", 32'(log_gnt[6]), 32'b10000);

    // 5a: last on the grant cycle -> single-cycle ownership
    clear_logs();
    for (int k = 0; k < 3; k++) step(5'b00010, 5'b00010);
    step('0, '0);
    check_val("t5_one_cycle", 32'(count_ones(log_busy, 0, 3)), 32'd1);
    check_val("t5_gnt1", 32'(log_gnt[1]), 32'b00010);
    // 5b: move the pointer to 0
    for (int k = 0; k < 2; k++) step(5'b00001, 5'b00001);
    for (int k = 0; k < 2; k++) step('0, '0);
    // 5c: 1 owns; last_i[0] ignored; last coincides with watchdog limit
    clear_logs();
    for (int k = 0; k < 18; k++) step(5'b00011, (k == 16) ? 5'b00011 : 5'b00001);
    step('0, '0);
    check_val("t5_hold16", 32'(count_ones(log_busy, 0, 17)), 32'd16);
    check_val("t5_no_to", 32'(count_ones(log_to, 0, 17)), 32'd0);
    check_val("t5_ignore0", 32'(log_gnt[5]), 32'b00010);
    check_val("t5_gap", 32'(log_gnt[17]), 32'd0);

    // 6: asynchronous reset mid-ownership
    for (int k = 0; k < 3; k++) step(5'b00100, '0);
    #1;
    rst = 1'b1;
    #1;
    check_val("t6_async_gnt", 32'(bus.gnt_o), 32'd0);
    check_val("t6_async_busy", 32'(bus.busy_o), 32'd0);
    check_val("t6_async_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    bus.req_i = '0;
    @(posedge clk);
    #1;
    model_reset();
    clear_logs();
    for (int k = 0; k < 3; k++) step(5'b10001, '0);
    check_val("t6_first0", 32'(log_gnt[1]), 32'b00001);
    for (int k = 0; k < 3; k++) step('0, '0);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      r = NR'($urandom_range(0, 31));
      l = NR'($urandom_range(0, 31)) & NR'($urandom_range(0, 31));
      step(r, l);
    end
    for (int k = 0; k < 4; k++) step('0, '0);
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
